// File: rtl/bitfield_feeder.sv
// ---------------------------------------------------------------------------
// bitfield_feeder
//
// Double-buffered bit-field extractor front end. Packed 16-bit words are
// buffered in a current/next pair and consumed LSB-first. For each accepted
// field request the block produces a coarse-aligned 16-bit window (sh_din),
// a fine shift of 0..7 (sh_shift) and a field mask (sh_mask). These feed a
// downstream fine-shift stage one cycle after the request is accepted.
//
// Ports
//   clk         in   1  single clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   flush       in   1  synchronous clear of all buffered bits
//   word_valid  in   1  upstream word present
//   word_data   in  16  upstream packed word
//   word_ready  out  1  word_data accepted this cycle (combinational)
//   req_valid   in   1  field request
//   req_len     in   4  field length 1..8 (0 or >8 is treated as 8)
//   req_ready   out  1  request accepted this cycle (combinational)
//   sh_din      out 16  coarse-aligned data window
//   sh_shift    out  4  fine shift amount 0..7
//   sh_mask     out 16  field mask applied after the shift
//   sh_valid    out  1  one-cycle strobe qualifying the sh_* outputs
//
// Configuration macro
//   BITFIELD_FEEDER_MASK_EN  defined: sh_mask is a register holding
//                            (1 << len) - 1 for each accepted request.
//                            undefined: sh_mask is tied to 16'hFFFF.
// ---------------------------------------------------------------------------
module bitfield_feeder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        word_valid,
    input  logic [15:0] word_data,
    output logic        word_ready,
    input  logic        req_valid,
    input  logic [3:0]  req_len,
    output logic        req_ready,
    output logic [15:0] sh_din,
    output logic [3:0]  sh_shift,
    output logic [15:0] sh_mask,
    output logic        sh_valid
);

    logic [15:0] cur_r;
    logic [15:0] next_r;
    logic        cur_v_r;
    logic        next_v_r;
    logic [4:0]  ptr_r;

    logic [3:0]  len_s;
    logic [4:0]  sum_s;
    logic        acc_s;
    logic        wrap_s;
    logic        wload_s;
    logic        cur_free_s;
    logic [15:0] din_s;

    // Request/word handshake decode and coarse window selection.
    always_comb begin
        len_s      = 4'd8;
        sum_s      = 5'd0;
        req_ready  = 1'b0;
        acc_s      = 1'b0;
        wrap_s     = 1'b0;
        word_ready = 1'b0;
        wload_s    = 1'b0;
        cur_free_s = 1'b0;
        din_s      = 16'd0;

        if ((req_len == 4'd0) || (req_len > 4'd8)) begin
            len_s = 4'd8;
        end else begin
            len_s = req_len;
        end

        sum_s = ptr_r + {1'b0, len_s};

        // A field that runs past the end of cur needs next to be present.
        req_ready = cur_v_r && (next_v_r || (sum_s <= 5'd16)) && !flush;
        acc_s     = req_valid && req_ready;
        wrap_s    = acc_s && (sum_s >= 5'd16);

        word_ready = !next_v_r && !flush;
        wload_s    = word_valid && word_ready;

        // cur is free for an incoming word if it is already empty or is
        // fully consumed this cycle with nothing in next to promote.
        cur_free_s = !cur_v_r || (wrap_s && !next_v_r);

        // Pointers 8..15 take the upper half of cur plus the low byte of
        // next, so the fine shift never exceeds 7.
        if (ptr_r[3] == 1'b0) begin
            din_s = cur_r;
        end else begin
            din_s = {next_r[7:0], cur_r[15:8]};
        end
    end

    // Word buffer, valid flags and read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_r    <= 16'd0;
            next_r   <= 16'd0;
            cur_v_r  <= 1'b0;
            next_v_r <= 1'b0;
            ptr_r    <= 5'd0;
        end else if (flush) begin
            cur_r    <= 16'd0;
            next_r   <= 16'd0;
            cur_v_r  <= 1'b0;
            next_v_r <= 1'b0;
            ptr_r    <= 5'd0;
        end else begin
            if (acc_s) begin
                if (wrap_s) begin
                    cur_r    <= next_r;
                    cur_v_r  <= next_v_r;
                    next_v_r <= 1'b0;
                    ptr_r    <= sum_s - 5'd16;
                end else begin
                    ptr_r    <= sum_s;
                end
            end else begin
                ptr_r <= ptr_r;
            end

            // Word load is evaluated after consumption so a word arriving
            // on an exact word boundary lands directly in cur.
            if (wload_s) begin
                if (cur_free_s) begin
                    cur_r   <= word_data;
                    cur_v_r <= 1'b1;
                end else begin
                    next_r   <= word_data;
                    next_v_r <= 1'b1;
                end
            end else begin
                next_r <= next_r;
            end
        end
    end

    // Registered fine-shift stage outputs, valid one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_din   <= 16'd0;
            sh_shift <= 4'd0;
            sh_valid <= 1'b0;
        end else if (flush) begin
            sh_valid <= 1'b0;
        end else begin
            sh_valid <= acc_s;
            if (acc_s) begin
                sh_din   <= din_s;
                sh_shift <= {1'b0, ptr_r[2:0]};
            end else begin
                sh_din   <= sh_din;
                sh_shift <= sh_shift;
            end
        end
    end

`ifdef BITFIELD_FEEDER_MASK_EN
    function automatic logic [15:0] field_mask(input logic [3:0] len);
        return (16'd1 << len) - 16'd1;
    endfunction

    // Field mask register, loaded alongside sh_din on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mask <= 16'd0;
        end else if (flush) begin
            sh_mask <= sh_mask;
        end else if (acc_s) begin
            sh_mask <= field_mask(len_s);
        end else begin
            sh_mask <= sh_mask;
        end
    end
`else
    assign sh_mask = 16'hFFFF;
`endif

endmodule

// File: tb/tb_bitfield_feeder.sv
// ---------------------------------------------------------------------------
// tb_bitfield_feeder
//
// Directed self-checking bench for bitfield_feeder. Inputs are driven 1 time
// unit after the rising edge; combinational handshakes are sampled 1 unit
// later, registered outputs 1 unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_bitfield_feeder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        word_valid;
    logic [15:0] word_data;
    logic        word_ready;
    logic        req_valid;
    logic [3:0]  req_len;
    logic        req_ready;
    logic [15:0] sh_din;
    logic [3:0]  sh_shift;
    logic [15:0] sh_mask;
    logic        sh_valid;

    int total;
    int passed;
    int failed;

    bitfield_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .sh_din     (sh_din),
        .sh_shift   (sh_shift),
        .sh_mask    (sh_mask),
        .sh_valid   (sh_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected mask for the current build configuration.
    function automatic logic [15:0] em(input logic [15:0] v);
`ifdef BITFIELD_FEEDER_MASK_EN
        return v;
`else
        return 16'hFFFF;
`endif
    endfunction

    // Expected mask while still in reset.
    function automatic logic [15:0] em_rst();
`ifdef BITFIELD_FEEDER_MASK_EN
        return 16'h0000;
`else
        return 16'hFFFF;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic wv, input logic [15:0] wd,
                         input logic rv, input logic [3:0] rl);
        flush      = f;
        word_valid = wv;
        word_data  = wd;
        req_valid  = rv;
        req_len    = rl;
        #1;
    endtask

    task automatic chk_sh(input string tag, input logic [15:0] din,
                          input logic [3:0] shift, input logic [15:0] mask);
        chk({tag, "_valid"}, {15'd0, sh_valid}, 16'd1);
        chk({tag, "_din"},   sh_din, din);
        chk({tag, "_shift"}, {12'd0, sh_shift}, {12'd0, shift});
        chk({tag, "_mask"},  sh_mask, mask);
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        rst_n = 1'b0;
        flush = 1'b0; word_valid = 1'b0; word_data = 16'd0;
        req_valid = 1'b0; req_len = 4'd0;
        #2;
        // Reset state
        chk("rst_sh_valid", {15'd0, sh_valid}, 16'd0);
        chk("rst_sh_din", sh_din, 16'd0);
        chk("rst_sh_shift", {12'd0, sh_shift}, 16'd0);
        chk("rst_sh_mask", sh_mask, em_rst());
        chk("rst_req_ready", {15'd0, req_ready}, 16'd0);
        chk("rst_word_ready", {15'd0, word_ready}, 16'd1);
        tick();
        rst_n = 1'b1;

        // Load 0x1234 while empty: no request can be accepted
        drive(1'b0, 1'b1, 16'h1234, 1'b1, 4'd4);
        chk("empty_req_ready", {15'd0, req_ready}, 16'd0);
        chk("w1_word_ready", {15'd0, word_ready}, 16'd1);
        tick();
        chk("empty_no_valid", {15'd0, sh_valid}, 16'd0);

        // Load 0xABCD into next while taking the first 4 bits
        drive(1'b0, 1'b1, 16'hABCD, 1'b1, 4'd4);
        chk("a1_req_ready", {15'd0, req_ready}, 16'd1);
        tick();
        chk_sh("a1", 16'h1234, 4'd0, em(16'h000F));
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd4);
        chk("full_word_ready", {15'd0, word_ready}, 16'd0);
        tick();
        chk_sh("a2", 16'h1234, 4'd4, em(16'h000F));

        // len 8 at ptr 8: straddles cur/next, promotes next to cur
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd8);
        tick();
        chk_sh("a3", 16'hCD12, 4'd0, em(16'h00FF));
        // len 0 behaves as 8 and reads the promoted word from ptr 0
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd0);
        chk("a4_word_ready", {15'd0, word_ready}, 16'd1);
        tick();
        chk_sh("a4", 16'hABCD, 4'd0, em(16'h00FF));
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 4'd0);
        tick();
        chk("pulse_drop", {15'd0, sh_valid}, 16'd0);

        // Flush beats simultaneous word and request
        drive(1'b1, 1'b1, 16'h1111, 1'b1, 4'd4);
        chk("fl_word_ready", {15'd0, word_ready}, 16'd0);
        chk("fl_req_ready", {15'd0, req_ready}, 16'd0);
        tick();
        chk("fl_sh_valid", {15'd0, sh_valid}, 16'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd1);
        chk("fl_cur_empty", {15'd0, req_ready}, 16'd1 ^ 16'd1);
        chk("fl_next_empty", {15'd0, word_ready}, 16'd1);

        // Single word 0x00F0, walk ptr to 12
        drive(1'b0, 1'b1, 16'h00F0, 1'b0, 4'd0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd6);
        tick();
        chk_sh("b1", 16'h00F0, 4'd0, em(16'h003F));
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd6);
        tick();
        chk_sh("b2", 16'h00F0, 4'd6, em(16'h003F));

        // ptr 12 + len 8 needs a second word
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd8);
        chk("b3_stall", {15'd0, req_ready}, 16'd0);
        tick();
        chk("b3_no_valid", {15'd0, sh_valid}, 16'd0);
        drive(1'b0, 1'b1, 16'h5AC3, 1'b1, 4'd8);
        chk("b3_stall_w", {15'd0, req_ready}, 16'd0);
        tick();
        chk("b3_no_valid_w", {15'd0, sh_valid}, 16'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd8);
        chk("b3_ready", {15'd0, req_ready}, 16'd1);
        tick();
        chk_sh("b3", 16'hC300, 4'd4, em(16'h00FF));

        // ptr 4 -> 10 in 0x5AC3
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd6);
        tick();
        chk_sh("c1", 16'h5AC3, 4'd4, em(16'h003F));
        // Exact boundary with a word arriving the same cycle
        drive(1'b0, 1'b1, 16'h5555, 1'b1, 4'd6);
        chk("c2_req_ready", {15'd0, req_ready}, 16'd1);
        chk("c2_word_ready", {15'd0, word_ready}, 16'd1);
        tick();
        chk("c2_valid", {15'd0, sh_valid}, 16'd1);
        chk("c2_shift", {12'd0, sh_shift}, 16'd2);
        chk("c2_mask", sh_mask, em(16'h003F));
        // 0x5555 sits in cur at ptr 0; another word goes to next
        drive(1'b0, 1'b1, 16'h7777, 1'b1, 4'd4);
        chk("c3_req_ready", {15'd0, req_ready}, 16'd1);
        chk("c3_word_ready", {15'd0, word_ready}, 16'd1);
        tick();
        chk_sh("c3", 16'h5555, 4'd0, em(16'h000F));

        // Reset one cycle after an accept
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd4);
        chk("r_sh_valid", {15'd0, sh_valid}, 16'd0);
        chk("r_sh_din", sh_din, 16'd0);
        chk("r_sh_shift", {12'd0, sh_shift}, 16'd0);
        chk("r_sh_mask", sh_mask, em_rst());
        chk("r_req_ready", {15'd0, req_ready}, 16'd0);
        chk("r_word_ready", {15'd0, word_ready}, 16'd1);
        tick();
        rst_n = 1'b1;

        // Length clamp (9 -> 8) and exact boundary without a new word
        drive(1'b0, 1'b1, 16'h3C5A, 1'b0, 4'd0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd9);
        tick();
        chk_sh("d1", 16'h3C5A, 4'd0, em(16'h00FF));
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd15);
        tick();
        chk("d2_valid", {15'd0, sh_valid}, 16'd1);
        chk("d2_shift", {12'd0, sh_shift}, 16'd0);
        chk("d2_mask", sh_mask, em(16'h00FF));
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 4'd1);
        chk("d3_empty", {15'd0, req_ready}, 16'd0);
        tick();
        chk("d3_no_valid", {15'd0, sh_valid}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
